// File: rtl/cdm_acc_pkg.sv
// ============================================================================
// cdm_acc_pkg : state encoding and default widths for the cdm16 accumulation stage
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cdm_acc_pkg;

   localparam int unsigned CDM_PW = 32;
   localparam int unsigned CDM_AW = 40;
   localparam int unsigned CDM_CW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/cdm_acc_add.sv
// ============================================================================
// cdm_acc_add : AW-bit unsigned adder with carry-out; clamps to all-ones on
//               carry when CDM_ACC_SAT_EN is defined, otherwise wraps.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cdm_acc_add #(
   parameter int unsigned AW = 40
) (
   input  logic [AW-1:0] i_a,
   input  logic [AW-1:0] i_b,
   output logic [AW-1:0] o_sum,
   output logic          o_carry
);

   logic [AW-1:0] w_raw;
   logic          w_carry;

   assign {w_carry, w_raw} = {1'b0, i_a} + {1'b0, i_b};
   assign o_carry          = w_carry;

`ifdef CDM_ACC_SAT_EN
   // A clamped accumulator is all-ones, so any further non-zero term carries again and stays clamped.
   assign o_sum = w_carry ? {AW{1'b1}} : w_raw;
`else
   assign o_sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/cdm16_acc_stage.sv
// ============================================================================
// cdm16_acc_stage : sums len unsigned products from cdm16_f883 over valid/ready
//                   and presents the result on a valid/ready port.
//                   Optional saturation: define CDM_ACC_SAT_EN.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module cdm16_acc_stage
   import cdm_acc_pkg::*;
#(
   parameter int unsigned PW = CDM_PW,
   parameter int unsigned AW = CDM_AW,
   parameter int unsigned CW = CDM_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          p_valid,
   output logic          p_ready,
   input  logic [PW-1:0] p_data,
   output logic          acc_valid,
   input  logic          acc_ready,
   output logic [AW-1:0] acc_data,
   output logic          acc_ovf,
   output logic          busy
);

   acc_state_t    r_state;
   logic [AW-1:0] r_acc;
   logic          r_ovf;
   logic [CW-1:0] r_count;

   logic [AW-1:0] w_p_ext;
   logic [AW-1:0] w_sum;
   logic          w_carry;
   logic          w_take;

   assign w_p_ext = AW'(p_data);
   assign w_take  = p_valid && p_ready;

   cdm_acc_add #(.AW(AW)) u_add (
      .i_a     (r_acc),
      .i_b     (w_p_ext),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_count   <= '0;
         acc_data  <= '0;
         acc_ovf   <= 1'b0;
         acc_valid <= 1'b0;
         p_ready   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_acc <= '0;
                  r_ovf <= 1'b0;
                  busy  <= 1'b1;
                  if (len != '0) begin
                     r_count <= len;
                     p_ready <= 1'b1;
                     r_state <= ST_ACC;
                  end else begin
                     acc_data  <= '0;
                     acc_ovf   <= 1'b0;
                     acc_valid <= 1'b1;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_ACC: begin
               if (w_take) begin
                  r_acc   <= w_sum;
                  r_ovf   <= r_ovf | w_carry;
                  r_count <= r_count - CW'(1);
                  // Result registers load straight from the adder so the last term is included.
                  if (r_count == CW'(1)) begin
                     acc_data  <= w_sum;
                     acc_ovf   <= r_ovf | w_carry;
                     acc_valid <= 1'b1;
                     p_ready   <= 1'b0;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (acc_ready) begin
                  acc_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               acc_valid <= 1'b0;
               p_ready   <= 1'b0;
               busy      <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cdm16_acc_stage.sv
// ============================================================================
// tb_cdm16_acc_stage : directed self-checking bench for cdm16_acc_stage (AW=33).
//                      Overflow expectation follows CDM_ACC_SAT_EN.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_cdm16_acc_stage;

   localparam int unsigned PW = 32;
   localparam int unsigned AW = 33;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic          p_valid = 1'b0;
   logic          p_ready;
   logic [PW-1:0] p_data = '0;
   logic          acc_valid;
   logic          acc_ready = 1'b0;
   logic [AW-1:0] acc_data;
   logic          acc_ovf;
   logic          busy;

   int n_pass = 0;
   int n_total = 0;
   int n_acc = 0;
   int n_pready = 0;

   cdm16_acc_stage #(.PW(PW), .AW(AW), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .p_valid   (p_valid),
      .p_ready   (p_ready),
      .p_data    (p_data),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .acc_data  (acc_data),
      .acc_ovf   (acc_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (p_valid && p_ready) n_acc <= n_acc + 1;
      if (p_ready) n_pready <= n_pready + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [CW-1:0] l);
      start = 1'b1;
      len   = l;
      tick(1);
      start = 1'b0;
      len   = '0;
   endtask

   // Returns #1 after the accepting edge.
   task automatic send_term(input logic [PW-1:0] d);
      int budget;
      budget  = 50;
      p_valid = 1'b1;
      p_data  = d;
      while (!p_ready && budget > 0) begin
         tick(1);
         budget--;
      end
      if (budget == 0) chk("send_timeout", 64'd0, 64'd1);
      tick(1);
      p_valid = 1'b0;
      p_data  = '0;
   endtask

   task automatic take_result();
      acc_ready = 1'b1;
      tick(1);
      acc_ready = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] exp_ovf_data;
      #2;
      chk("rst_valid", 64'(acc_valid), 64'd0);
      chk("rst_pready", 64'(p_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(acc_data), 64'd0);
      chk("rst_ovf", 64'(acc_ovf), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // 1 basic
      do_start(8'd3);
      chk("t1_pready", 64'(p_ready), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      send_term(32'h10);
      send_term(32'h20);
      chk("t1_novalid", 64'(acc_valid), 64'd0);
      send_term(32'h30);
      chk("t1_valid", 64'(acc_valid), 64'd1);
      chk("t1_data", 64'(acc_data), 64'h60);
      chk("t1_ovf", 64'(acc_ovf), 64'd0);
      chk("t1_pready_done", 64'(p_ready), 64'd0);
      take_result();
      chk("t1_idle_valid", 64'(acc_valid), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);

      // 2 zero length
      n_pready = 0;
      do_start(8'd0);
      chk("t2_valid", 64'(acc_valid), 64'd1);
      chk("t2_data", 64'(acc_data), 64'd0);
      chk("t2_ovf", 64'(acc_ovf), 64'd0);
      take_result();
      tick(1);
      chk("t2_pready_never", 64'(n_pready), 64'd0);

      // 3 gaps
      n_acc = 0;
      do_start(8'd4);
      for (int k = 0; k < 4; k++) begin
         send_term(32'h0000_0100);
         if (k < 3) begin
            tick(3);
            chk("t3_hold_pready", 64'(p_ready), 64'd1);
         end
      end
      chk("t3_valid", 64'(acc_valid), 64'd1);
      chk("t3_data", 64'(acc_data), 64'h400);
      p_valid = 1'b1;
      p_data  = 32'hDEAD;
      tick(2);
      p_valid = 1'b0;
      chk("t3_accepts", 64'(n_acc), 64'd4);
      take_result();

      // 4 backpressure
      do_start(8'd2);
      send_term(32'd1);
      send_term(32'd2);
      for (int k = 0; k < 6; k++) begin
         if (k == 2) begin
            start = 1'b1;
            len   = 8'd5;
         end
         tick(1);
         start = 1'b0;
         len   = '0;
         chk("t4_data_stable", 64'(acc_data), 64'd3);
         chk("t4_busy", 64'(busy), 64'd1);
         chk("t4_valid", 64'(acc_valid), 64'd1);
      end
      start     = 1'b1;
      len       = 8'd7;
      acc_ready = 1'b1;
      tick(1);
      start     = 1'b0;
      len       = '0;
      acc_ready = 1'b0;
      tick(1);
      chk("t4_idle_busy", 64'(busy), 64'd0);
      chk("t4_idle_pready", 64'(p_ready), 64'd0);

      // 5 overflow
`ifdef CDM_ACC_SAT_EN
      exp_ovf_data = 33'h1_FFFF_FFFF;
`else
      exp_ovf_data = 33'h0_FFFF_FFFD;
`endif
      do_start(8'd3);
      send_term(32'hFFFF_FFFF);
      send_term(32'hFFFF_FFFF);
      send_term(32'hFFFF_FFFF);
      chk("t5_valid", 64'(acc_valid), 64'd1);
      chk("t5_data", 64'(acc_data), 64'(exp_ovf_data));
      chk("t5_ovf", 64'(acc_ovf), 64'd1);
      take_result();

      // 6 reset mid-job
      do_start(8'd4);
      send_term(32'd7);
      send_term(32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(acc_valid), 64'd0);
      chk("t6_rst_pready", 64'(p_ready), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_data", 64'(acc_data), 64'd0);
      chk("t6_rst_ovf", 64'(acc_ovf), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      do_start(8'd1);
      send_term(32'h5);
      chk("t6_valid", 64'(acc_valid), 64'd1);
      chk("t6_data", 64'(acc_data), 64'h5);
      chk("t6_ovf", 64'(acc_ovf), 64'd0);
      take_result();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
